// File: rtl/modo_sequencer_pkg.sv
// Shared definitions for the MODO sequencer slice.
//   W / SW       : counter data width and step-count field width
//   MODO_*       : mode codes understood by the MODO 4-bit counter
//   LOAD_MODE    : the code that makes MODO load its d input
//   state_e      : sequencer FSM states
package modo_sequencer_pkg;

    localparam int W  = 4;
    localparam int SW = 4;

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_HOLD = 2'b10;
    localparam logic [1:0] MODO_LOAD = 2'b11;
    localparam logic [1:0] LOAD_MODE = MODO_LOAD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/modo_sequencer_if.sv
// Client-side handshake bundle for the MODO sequencer.
//   req_x/mode_x/init_x/steps_x : request and job fields from client A/B
//   gnt_x                       : client owns the counter
//   done_x                      : one-cycle pulse, result/wrap valid
//   result/wrap                 : final count and wrap flag of last job
//   busy                        : sequencer is not idle
// master = client side, slave = sequencer side.
interface modo_sequencer_if;
    import modo_sequencer_pkg::*;

    logic          req_a;
    logic [1:0]    mode_a;
    logic [W-1:0]  init_a;
    logic [SW-1:0] steps_a;
    logic          req_b;
    logic [1:0]    mode_b;
    logic [W-1:0]  init_b;
    logic [SW-1:0] steps_b;
    logic          gnt_a;
    logic          gnt_b;
    logic          done_a;
    logic          done_b;
    logic [W-1:0]  result;
    logic          wrap;
    logic          busy;

    modport master (
        output req_a, mode_a, init_a, steps_a,
        output req_b, mode_b, init_b, steps_b,
        input  gnt_a, gnt_b, done_a, done_b, result, wrap, busy
    );

    modport slave (
        input  req_a, mode_a, init_a, steps_a,
        input  req_b, mode_b, init_b, steps_b,
        output gnt_a, gnt_b, done_a, done_b, result, wrap, busy
    );

endinterface

// File: rtl/modo_sequencer_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst  : clock, async active-low reset (pointer returns to A)
//   req_a/b   : current requests
//   advance   : pulse when a job finishes; pointer moves to the other client
//   served_b  : which client the finishing job belonged to
//   pick_b    : 1 when B wins the current arbitration
module modo_sequencer_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    input  logic served_b,
    output logic pick_b
);

    logic ptr_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_b <= 1'b0;
        end else if (advance) begin
            ptr_b <= ~served_b;
        end
    end

    // A lone requester always wins; the pointer only breaks ties.
    assign pick_b = req_b & (~req_a | ptr_b);

endmodule

// File: rtl/modo_sequencer.sv
// Two-client sequencer in front of one MODO 4-bit mode counter.
//   clk, rst          : clock, async active-low reset
//   cif (slave)       : client requests, grants, done pulses, result/wrap, busy
//   cnt_enable/modo/d : drive to the MODO counter
//   cnt_q, cnt_rco    : count and ripple-carry back from MODO
//
// state | meaning
// IDLE  | counter idle, arbitrate and latch winner's job
// LOAD  | one cycle, counter loads init
// RUN   | counter runs latched mode for `steps` edges
// DONE  | one cycle, capture count, pulse done, advance pointer
module modo_sequencer
    import modo_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    modo_sequencer_if.slave cif,
    output logic            cnt_enable,
    output logic [1:0]      cnt_modo,
    output logic [W-1:0]    cnt_d,
    input  logic [W-1:0]    cnt_q,
    input  logic            cnt_rco
);

    state_e        state;
    state_e        state_nxt;
    logic          owner_b;
    logic [1:0]    mode_l;
    logic [W-1:0]  init_l;
    logic [SW-1:0] steps_l;
    logic [SW-1:0] remaining;
    logic          wrap_acc;
    logic [W-1:0]  result_r;
    logic          wrap_r;
    logic          done_a_r;
    logic          done_b_r;
    logic          pick_b;
    logic          any_req;

    assign any_req = cif.req_a | cif.req_b;

    modo_sequencer_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_a    (cif.req_a),
        .req_b    (cif.req_b),
        .advance  (state == ST_DONE),
        .served_b (owner_b),
        .pick_b   (pick_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_enable = 1'b0;
        cnt_modo   = 2'b00;
        cnt_d      = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_enable = 1'b1;
                cnt_modo   = LOAD_MODE;
                cnt_d      = init_l;
                // A load-mode job or a zero-length job has nothing to run.
                if (steps_l == '0 || mode_l == LOAD_MODE) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_enable = 1'b1;
                cnt_modo   = mode_l;
                cnt_d      = init_l;
                if (remaining == SW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_b   <= 1'b0;
            mode_l    <= 2'b00;
            init_l    <= '0;
            steps_l   <= '0;
            remaining <= '0;
            wrap_acc  <= 1'b0;
            result_r  <= '0;
            wrap_r    <= 1'b0;
            done_a_r  <= 1'b0;
            done_b_r  <= 1'b0;
        end else begin
            done_a_r <= 1'b0;
            done_b_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_b <= pick_b;
                        mode_l  <= pick_b ? cif.mode_b  : cif.mode_a;
                        init_l  <= pick_b ? cif.init_b  : cif.init_a;
                        steps_l <= pick_b ? cif.steps_b : cif.steps_a;
                    end
                end
                ST_LOAD: begin
                    wrap_acc  <= 1'b0;
                    remaining <= steps_l;
                end
                ST_RUN: begin
                    remaining <= remaining - SW'(1);
                    wrap_acc  <= wrap_acc | cnt_rco;
                end
                ST_DONE: begin
                    result_r <= cnt_q;
                    wrap_r   <= wrap_acc;
                    done_a_r <= ~owner_b;
                    done_b_r <= owner_b;
                end
                default: begin
                end
            endcase
        end
    end

    assign cif.busy   = (state != ST_IDLE);
    assign cif.gnt_a  = (state != ST_IDLE) & ~owner_b;
    assign cif.gnt_b  = (state != ST_IDLE) &  owner_b;
    assign cif.done_a = done_a_r;
    assign cif.done_b = done_b_r;
    assign cif.result = result_r;
    assign cif.wrap   = wrap_r;

endmodule

// File: tb/tb_modo_sequencer.sv
// Directed bench for modo_sequencer with a behavioural MODO counter attached.
module tb_modo_sequencer;
    import modo_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cnt_enable;
    logic [1:0] cnt_modo;
    logic [3:0] cnt_d;
    logic [3:0] cnt_q;
    logic       cnt_rco;
    int checks = 0;
    int errors = 0;

    modo_sequencer_if cif ();

    modo_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cif        (cif),
        .cnt_enable (cnt_enable),
        .cnt_modo   (cnt_modo),
        .cnt_d      (cnt_d),
        .cnt_q      (cnt_q),
        .cnt_rco    (cnt_rco)
    );

    always #5 clk = ~clk;

    // MODO: 00 up, 01 down, 10 hold, 11 load; rco at terminal count of the active direction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'h0;
        end else if (cnt_enable) begin
            case (cnt_modo)
                2'b00:   cnt_q <= cnt_q + 4'h1;
                2'b01:   cnt_q <= cnt_q - 4'h1;
                2'b11:   cnt_q <= cnt_d;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
    assign cnt_rco = cnt_enable &&
                     ((cnt_modo == 2'b00 && cnt_q == 4'hF) || (cnt_modo == 2'b01 && cnt_q == 4'h0));

    task automatic run_job(input bit is_b, input logic [1:0] m, input logic [3:0] iv,
                           input logic [3:0] st, output int lat, output logic [3:0] res,
                           output logic wr, output int gcyc);
        lat = -1; res = 4'h0; wr = 1'b0; gcyc = 0;
        @(negedge clk);
        if (is_b) begin
            cif.req_b = 1'b1; cif.mode_b = m; cif.init_b = iv; cif.steps_b = st;
        end else begin
            cif.req_a = 1'b1; cif.mode_a = m; cif.init_a = iv; cif.steps_a = st;
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (is_b ? cif.gnt_b : cif.gnt_a) gcyc++;
            if (is_b ? cif.done_b : cif.done_a) begin
                lat = k; res = cif.result; wr = cif.wrap;
                break;
            end
        end
        cif.req_a = 1'b0;
        cif.req_b = 1'b0;
    endtask

    task automatic test_reset();
        cif.req_a = 0; cif.mode_a = 0; cif.init_a = 0; cif.steps_a = 0;
        cif.req_b = 0; cif.mode_b = 0; cif.init_b = 0; cif.steps_b = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cif.gnt_a, cif.gnt_b, cif.done_a, cif.done_b, cif.busy, cif.wrap, cif.result,
             cnt_enable, cnt_modo, cnt_d} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b%b done=%b%b busy=%b wrap=%b result=%0d en=%b modo=%0d d=%0d, expected all 0",
                     cif.gnt_a, cif.gnt_b, cif.done_a, cif.done_b, cif.busy, cif.wrap, cif.result,
                     cnt_enable, cnt_modo, cnt_d);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_a();
        int lat; logic [3:0] res; logic wr; int g;
        run_job(1'b0, MODO_UP, 4'd3, 4'd4, lat, res, wr, g);
        checks++; if (lat !== 6) begin errors++; $display("FAIL a_latency: got %0d expected 6", lat); end
        checks++; if (g !== 6) begin errors++; $display("FAIL a_gnt_cycles: got %0d expected 6", g); end
        checks++; if (res !== 4'd7) begin errors++; $display("FAIL a_result: got %0d expected 7", res); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL a_wrap: got %b expected 0", wr); end
    endtask

    task automatic test_single_b();
        int lat; logic [3:0] res; logic wr; int g;
        run_job(1'b1, MODO_UP, 4'd14, 4'd3, lat, res, wr, g);
        checks++; if (lat !== 5) begin errors++; $display("FAIL b_latency: got %0d expected 5", lat); end
        checks++; if (g !== 5) begin errors++; $display("FAIL b_gnt_cycles: got %0d expected 5", g); end
        checks++; if (res !== 4'd1) begin errors++; $display("FAIL b_result: got %0d expected 1", res); end
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL b_wrap: got %b expected 1", wr); end
    endtask

    // Both request together: A, then B, then A again while A keeps re-requesting.
    task automatic test_contention();
        int ta1 = -1, tb1 = -1, ta2 = -1, na = 0;
        logic [3:0] ra1 = 0, rb1 = 0, ra2 = 0;
        int both = 0;
        @(negedge clk);
        cif.req_a = 1; cif.mode_a = MODO_UP; cif.init_a = 4'd1; cif.steps_a = 4'd1;
        cif.req_b = 1; cif.mode_b = MODO_UP; cif.init_b = 4'd8; cif.steps_b = 4'd2;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (cif.gnt_a && cif.gnt_b) both++;
            if (cif.done_a) begin
                na++;
                if (na == 1) begin ta1 = k; ra1 = cif.result; end
                else begin ta2 = k; ra2 = cif.result; cif.req_a = 0; break; end
            end
            if (cif.done_b) begin tb1 = k; rb1 = cif.result; cif.req_b = 0; end
        end
        cif.req_a = 0; cif.req_b = 0;
        checks++; if (ta1 !== 3) begin errors++; $display("FAIL cont_first_a_time: got %0d expected 3", ta1); end
        checks++; if (ra1 !== 4'd2) begin errors++; $display("FAIL cont_first_a_result: got %0d expected 2", ra1); end
        checks++; if (tb1 !== 8) begin errors++; $display("FAIL cont_b_time: got %0d expected 8", tb1); end
        checks++; if (rb1 !== 4'd10) begin errors++; $display("FAIL cont_b_result: got %0d expected 10", rb1); end
        checks++; if (ta2 !== 12) begin errors++; $display("FAIL cont_second_a_time: got %0d expected 12", ta2); end
        checks++; if (ra2 !== 4'd2) begin errors++; $display("FAIL cont_second_a_result: got %0d expected 2", ra2); end
        checks++; if (both !== 0) begin errors++; $display("FAIL cont_dual_grant: got %0d cycles expected 0", both); end
    endtask

    task automatic test_load_only();
        int lat; logic [3:0] res; logic wr; int g;
        run_job(1'b0, MODO_UP, 4'd9, 4'd0, lat, res, wr, g);
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_steps_latency: got %0d expected 2", lat); end
        checks++; if (res !== 4'd9) begin errors++; $display("FAIL zero_steps_result: got %0d expected 9", res); end
        checks++; if (g !== 2) begin errors++; $display("FAIL zero_steps_gnt: got %0d expected 2", g); end
        run_job(1'b1, LOAD_MODE, 4'd6, 4'd5, lat, res, wr, g);
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_mode_latency: got %0d expected 2", lat); end
        checks++; if (res !== 4'd6) begin errors++; $display("FAIL load_mode_result: got %0d expected 6", res); end
    endtask

    task automatic test_boundary();
        int lat; logic [3:0] res; logic wr; int g;
        run_job(1'b0, MODO_UP, 4'd0, 4'd15, lat, res, wr, g);
        checks++; if (lat !== 17) begin errors++; $display("FAIL max_steps_latency: got %0d expected 17", lat); end
        checks++; if (g !== 17) begin errors++; $display("FAIL max_steps_gnt: got %0d expected 17", g); end
        checks++; if (res !== 4'd15) begin errors++; $display("FAIL max_steps_result: got %0d expected 15", res); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL max_steps_wrap: got %b expected 0", wr); end
        run_job(1'b1, MODO_DOWN, 4'd2, 4'd4, lat, res, wr, g);
        checks++; if (lat !== 6) begin errors++; $display("FAIL down_latency: got %0d expected 6", lat); end
        checks++; if (res !== 4'd14) begin errors++; $display("FAIL down_result: got %0d expected 14", res); end
        checks++; if (wr !== 1'b1) begin errors++; $display("FAIL down_wrap: got %b expected 1", wr); end
    endtask

    task automatic test_req_drop();
        int lat = -1; logic [3:0] res = 0;
        @(negedge clk);
        cif.req_a = 1; cif.mode_a = MODO_UP; cif.init_a = 4'd5; cif.steps_a = 4'd3;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin cif.mode_a = MODO_DOWN; cif.init_a = 4'd0; cif.steps_a = 4'd1; end
            if (k == 2) cif.req_a = 0;
            if (cif.done_a) begin lat = k; res = cif.result; break; end
        end
        cif.req_a = 0;
        checks++; if (lat !== 5) begin errors++; $display("FAIL drop_latency: got %0d expected 5", lat); end
        checks++; if (res !== 4'd8) begin errors++; $display("FAIL drop_result: got %0d expected 8", res); end
    endtask

    // Previous job was A, so the pointer sits on B until reset pulls it back to A.
    task automatic test_reset_midrun();
        int bad = 0; int first = -1; logic first_b = 0;
        @(negedge clk);
        cif.req_a = 1; cif.mode_a = MODO_UP; cif.init_a = 4'd3; cif.steps_a = 4'd10;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({cif.gnt_a, cif.gnt_b, cif.done_a, cif.done_b, cif.busy, cif.wrap, cif.result,
             cnt_enable, cnt_modo, cnt_d} !== 15'h0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got gnt=%b%b done=%b%b busy=%b wrap=%b result=%0d en=%b modo=%0d d=%0d, expected all 0",
                     cif.gnt_a, cif.gnt_b, cif.done_a, cif.done_b, cif.busy, cif.wrap, cif.result,
                     cnt_enable, cnt_modo, cnt_d);
        end
        cif.req_a = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (cif.done_a || cif.done_b || cif.busy) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", bad); end
        @(negedge clk);
        cif.req_a = 1; cif.mode_a = MODO_UP; cif.init_a = 4'd1; cif.steps_a = 4'd1;
        cif.req_b = 1; cif.mode_b = MODO_UP; cif.init_b = 4'd8; cif.steps_b = 4'd1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (cif.done_a || cif.done_b) begin first = k; first_b = cif.done_b; break; end
        end
        cif.req_a = 0; cif.req_b = 0;
        checks++; if (first !== 3) begin errors++; $display("FAIL post_reset_done_time: got %0d expected 3", first); end
        checks++; if (first_b !== 1'b0) begin errors++; $display("FAIL post_reset_pointer: got winner_b=%b expected 0", first_b); end
        repeat (6) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_single_b();
        test_contention();
        test_load_only();
        test_boundary();
        test_req_drop();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
